// File: rtl/esp_dma64_responder.sv
// Memory-side responder for the ESP 64-bit DMA interface: streams reads from / sinks writes into a local memory.
// Optional bounds checking is enabled by defining ESP_DMA_RESP_BOUNDS_CHECK_EN; otherwise addresses wrap modulo DEPTH.
module esp_dma64_responder #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dma_read_ctrl_valid,
    output logic          dma_read_ctrl_ready,
    input  logic [31:0]   dma_read_ctrl_data_index,
    input  logic [31:0]   dma_read_ctrl_data_length,
    input  logic [2:0]    dma_read_ctrl_data_size,
    output logic          dma_read_chnl_valid,
    input  logic          dma_read_chnl_ready,
    output logic [63:0]   dma_read_chnl_data,
    input  logic          dma_write_ctrl_valid,
    output logic          dma_write_ctrl_ready,
    input  logic [31:0]   dma_write_ctrl_data_index,
    input  logic [31:0]   dma_write_ctrl_data_length,
    input  logic [2:0]    dma_write_ctrl_data_size,
    input  logic          dma_write_chnl_valid,
    output logic          dma_write_chnl_ready,
    input  logic [63:0]   dma_write_chnl_data,
    input  logic          host_en,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [63:0]   host_wdata,
    output logic [63:0]   host_rdata,
    output logic          busy,
    output logic          err_oob
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t       r_state, w_next;
    logic [63:0]  r_mem [DEPTH];
    logic [31:0]  r_addr, r_cnt;
    logic [2:0]   r_size;
    logic         r_rr_wr;
    logic [63:0]  r_fifo [2];
    logic         r_wp, r_rp;
    logic [1:0]   r_fcnt;
    logic [63:0]  r_host_rdata;

    logic         w_rd_win, w_wr_win, w_rd_hs, w_wr_hs;
    logic         w_pop, w_issue, w_wbeat, w_oob, w_host_ok;
    logic         w_mem_we;
    logic [AW-1:0] w_maddr, w_mem_waddr;
    logic [63:0]  w_mem_wdata, w_rd_word;
    logic         w_unused;

    assign w_maddr  = r_addr[AW-1:0];
    assign w_rd_win = dma_read_ctrl_valid  && (!dma_write_ctrl_valid || !r_rr_wr);
    assign w_wr_win = dma_write_ctrl_valid && (!dma_read_ctrl_valid  ||  r_rr_wr);
    assign w_rd_hs  = dma_read_ctrl_valid  && dma_read_ctrl_ready;
    assign w_wr_hs  = dma_write_ctrl_valid && dma_write_ctrl_ready;
    assign w_pop    = dma_read_chnl_valid  && dma_read_chnl_ready;
    assign w_wbeat  = dma_write_chnl_valid && dma_write_chnl_ready;

    assign dma_read_chnl_valid = (r_fcnt != 2'd0);
    assign dma_read_chnl_data  = r_fifo[r_rp];
    assign host_rdata          = r_host_rdata;
    assign busy                = (r_state != S_IDLE);
    // Transfer size is captured for visibility only; nothing downstream uses it.
    assign w_unused            = ^r_size;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next               = r_state;
        dma_read_ctrl_ready  = 1'b0;
        dma_write_ctrl_ready = 1'b0;
        dma_write_chnl_ready = 1'b0;
        w_issue              = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                dma_read_ctrl_ready  = w_rd_win;
                dma_write_ctrl_ready = w_wr_win;
                if (w_rd_win)      w_next = S_RD;
                else if (w_wr_win) w_next = S_WR;
            end
            S_RD: begin
                // Memory data lands straight in the FIFO, so a slot must be free or draining now.
                w_issue = (r_cnt != 32'd0) && ((r_fcnt != 2'd2) || w_pop);
                if ((r_cnt == 32'd0) && ((r_fcnt == 2'd0) || ((r_fcnt == 2'd1) && w_pop)))
                    w_next = S_IDLE;
            end
            S_WR: begin
                dma_write_chnl_ready = (r_cnt != 32'd0);
                if ((r_cnt == 32'd0) || ((r_cnt == 32'd1) && w_wbeat))
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

`ifdef ESP_DMA_RESP_BOUNDS_CHECK_EN
    logic r_err;
    assign w_oob     = |r_addr[31:AW];
    assign w_rd_word = w_oob ? 64'hDEADBEEF_DEADBEEF : r_mem[w_maddr];
    assign err_oob   = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          r_err <= 1'b0;
        else if ((w_issue || w_wbeat) && w_oob) r_err <= 1'b1;
    end
`else
    assign w_oob     = 1'b0;
    assign w_rd_word = r_mem[w_maddr];
    assign err_oob   = 1'b0;
`endif

    // Host owns the memory port only in an IDLE cycle with no ctrl handshake.
    assign w_host_ok   = (r_state == S_IDLE) && host_en && !w_rd_hs && !w_wr_hs;
    assign w_mem_we    = (w_wbeat && !w_oob) || (w_host_ok && host_we);
    assign w_mem_waddr = w_wbeat ? w_maddr : host_addr;
    assign w_mem_wdata = w_wbeat ? dma_write_chnl_data : host_wdata;

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr       <= '0;
            r_cnt        <= '0;
            r_size       <= '0;
            r_rr_wr      <= 1'b0;
            r_wp         <= 1'b0;
            r_rp         <= 1'b0;
            r_fcnt       <= '0;
            r_host_rdata <= '0;
            for (int i = 0; i < 2; i++) r_fifo[i] <= '0;
        end else begin
            if (w_rd_hs) begin
                r_addr <= dma_read_ctrl_data_index;
                r_cnt  <= dma_read_ctrl_data_length;
                r_size <= dma_read_ctrl_data_size;
            end else if (w_wr_hs) begin
                r_addr <= dma_write_ctrl_data_index;
                r_cnt  <= dma_write_ctrl_data_length;
                r_size <= dma_write_ctrl_data_size;
            end else if (w_issue || w_wbeat) begin
                r_addr <= r_addr + 32'd1;
                r_cnt  <= r_cnt - 32'd1;
            end
            if ((w_rd_hs || w_wr_hs) && dma_read_ctrl_valid && dma_write_ctrl_valid)
                r_rr_wr <= ~r_rr_wr;
            if (w_issue) begin
                r_fifo[r_wp] <= w_rd_word;
                r_wp         <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_fcnt <= r_fcnt + 2'(w_issue) - 2'(w_pop);
            if (w_host_ok && !host_we) r_host_rdata <= r_mem[host_addr];
        end
    end
endmodule

// File: tb/tb_esp_dma64_responder.sv
// Directed bench for esp_dma64_responder: a memory model predicts every read beat, checked by one compare process.
module tb_esp_dma64_responder;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          dma_read_ctrl_valid = 1'b0, dma_read_ctrl_ready;
    logic [31:0]   dma_read_ctrl_data_index = '0, dma_read_ctrl_data_length = '0;
    logic [2:0]    dma_read_ctrl_data_size = '0;
    logic          dma_read_chnl_valid, dma_read_chnl_ready = 1'b1;
    logic [63:0]   dma_read_chnl_data;
    logic          dma_write_ctrl_valid = 1'b0, dma_write_ctrl_ready;
    logic [31:0]   dma_write_ctrl_data_index = '0, dma_write_ctrl_data_length = '0;
    logic [2:0]    dma_write_ctrl_data_size = '0;
    logic          dma_write_chnl_valid = 1'b0, dma_write_chnl_ready;
    logic [63:0]   dma_write_chnl_data = '0;
    logic          host_en = 1'b0, host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [63:0]   host_wdata = '0, host_rdata;
    logic          busy, err_oob;

    always #5 clk = ~clk;

    esp_dma64_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
        .dma_read_ctrl_data_index(dma_read_ctrl_data_index), .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
        .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_ready(dma_read_chnl_ready),
        .dma_read_chnl_data(dma_read_chnl_data),
        .dma_write_ctrl_valid(dma_write_ctrl_valid), .dma_write_ctrl_ready(dma_write_ctrl_ready),
        .dma_write_ctrl_data_index(dma_write_ctrl_data_index), .dma_write_ctrl_data_length(dma_write_ctrl_data_length),
        .dma_write_ctrl_data_size(dma_write_ctrl_data_size),
        .dma_write_chnl_valid(dma_write_chnl_valid), .dma_write_chnl_ready(dma_write_chnl_ready),
        .dma_write_chnl_data(dma_write_chnl_data),
        .host_en(host_en), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .busy(busy), .err_oob(err_oob)
    );

    int          checks = 0, errors = 0;
    logic [63:0] mdl [DEPTH];
    logic [63:0] exp_q [$];
    logic [63:0] last_beat = '0, stall_data = '0;
    int          nbeats = 0;
    bit          stall_pend = 1'b0;
    int          rmode = 0, tog_i = 0;
    logic [5:0]  tog_pat = 6'b101001;   // ready sequence 1,0,0,1,0,1 read from bit 0 upward

`ifdef ESP_DMA_RESP_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mdl_rd(input logic [31:0] a);
        if (BOUNDS && a >= DEPTH) return 64'hDEADBEEF_DEADBEEF;
        return mdl[a[AW-1:0]];
    endfunction

    always @(posedge clk) begin
        #1;
        if (rmode == 0) dma_read_chnl_ready = 1'b1;
        else begin
            dma_read_chnl_ready = tog_pat[tog_i % 6];
            tog_i++;
        end
    end

    // Single compare point for the read stream: order, content, stall stability.
    always @(negedge clk) begin
        if (!rst) stall_pend = 1'b0;
        else if (dma_read_chnl_valid) begin
            if (stall_pend) chk("rd_stable", dma_read_chnl_data, stall_data);
            if (dma_read_chnl_ready) begin
                stall_pend = 1'b0;
                if (exp_q.size() == 0) chk("rd_extra_beat", dma_read_chnl_valid, 1'b0);
                else begin
                    last_beat = dma_read_chnl_data;
                    nbeats++;
                    chk("rd_beat", dma_read_chnl_data, exp_q.pop_front());
                end
            end else begin
                stall_pend = 1'b1;
                stall_data = dma_read_chnl_data;
            end
        end else if (stall_pend) begin
            chk("rd_valid_held", dma_read_chnl_valid, 1'b1);
            stall_pend = 1'b0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
        chk("rd_missing", exp_q.size(), 0);
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic rd_task(input logic [31:0] idx, input logic [31:0] len, input bit lat, input bit drain);
        int n = 0;
        for (int k = 0; k < int'(len); k++) exp_q.push_back(mdl_rd(idx + k));
        dma_read_ctrl_valid       = 1'b1;
        dma_read_ctrl_data_index  = idx;
        dma_read_ctrl_data_length = len;
        dma_read_ctrl_data_size   = 3'd3;
        forever begin
            @(negedge clk);
            if (dma_read_ctrl_ready) break;
            n++;
            if (n > 100) begin chk("rd_ctrl_timeout", dma_read_ctrl_ready, 1'b1); break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        dma_read_ctrl_valid = 1'b0;
        if (lat) begin
            @(negedge clk); chk("rd_lat_c1", dma_read_chnl_valid, 1'b0);
            for (int k = 0; k < int'(len); k++) begin
                @(negedge clk); chk("rd_tput", dma_read_chnl_valid, 1'b1);
            end
            @(negedge clk); chk("rd_busy_fall", busy, 1'b0);
            @(posedge clk); #1;
        end
        if (drain) wait_idle();
    endtask

    task automatic wr_task(input logic [31:0] idx, input logic [31:0] len, input logic [63:0] base);
        int n = 0;
        logic [31:0] wa;
        dma_write_ctrl_valid       = 1'b1;
        dma_write_ctrl_data_index  = idx;
        dma_write_ctrl_data_length = len;
        dma_write_ctrl_data_size   = 3'd3;
        forever begin
            @(negedge clk);
            if (dma_write_ctrl_ready) break;
            n++;
            if (n > 100) begin chk("wr_ctrl_timeout", dma_write_ctrl_ready, 1'b1); break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        dma_write_ctrl_valid = 1'b0;
        for (int k = 0; k < int'(len); k++) begin
            wa = idx + k;
            if (!(BOUNDS && wa >= DEPTH)) mdl[wa[AW-1:0]] = base + k;
            dma_write_chnl_valid = 1'b1;
            dma_write_chnl_data  = base + k;
            n = 0;
            forever begin
                @(negedge clk);
                if (dma_write_chnl_ready) break;
                n++;
                if (n > 100) begin chk("wr_beat_timeout", dma_write_chnl_ready, 1'b1); break; end
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
        end
        dma_write_chnl_valid = 1'b0;
        wait_idle();
    endtask

    task automatic host_wr(input logic [AW-1:0] a, input logic [63:0] d);
        host_en = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        mdl[a] = d;
        @(posedge clk); #1;
        host_en = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_rd(input string nm, input logic [AW-1:0] a, input logic [63:0] exp);
        host_en = 1'b1; host_we = 1'b0; host_addr = a;
        @(posedge clk); #1;
        host_en = 1'b0;
        chk(nm, host_rdata, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_ctrl_ready"}, dma_read_ctrl_ready, 1'b0);
        chk({tag, "_wr_ctrl_ready"}, dma_write_ctrl_ready, 1'b0);
        chk({tag, "_rd_chnl_valid"}, dma_read_chnl_valid, 1'b0);
        chk({tag, "_rd_chnl_data"}, dma_read_chnl_data, 64'd0);
        chk({tag, "_wr_chnl_ready"}, dma_write_chnl_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err_oob"}, err_oob, 1'b0);
        chk({tag, "_host_rdata"}, host_rdata, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #13;
        chk_reset_outputs("por");
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 16; i++) host_wr(AW'(i), 64'(i));
        host_wr(AW'(DEPTH - 2), 64'hAAAA_0FFE);
        host_wr(AW'(DEPTH - 1), 64'hAAAA_0FFF);
        host_rd("host_rd5", AW'(5), 64'd5);

        // Plain read with latency and throughput checks
        nbeats = 0;
        rd_task(32'd4, 32'd8, 1'b1, 1'b1);
        chk("t1_last", last_beat, 64'd11);
        chk("t1_count", nbeats, 8);

        // Write then read back
        wr_task(32'd100, 32'd4, 64'hA0);
        rd_task(32'd100, 32'd4, 1'b0, 1'b1);
        chk("t2_last", last_beat, 64'hA3);
        host_rd("host_rd101", AW'(101), 64'hA1);

        // Read under toggling backpressure
        rmode = 1; nbeats = 0;
        rd_task(32'd2, 32'd6, 1'b0, 1'b1);
        rmode = 0;
        chk("t3_last", last_beat, 64'd7);
        chk("t3_count", nbeats, 6);

        // Both requests together: read first after reset
        dma_write_ctrl_valid = 1'b1; dma_write_ctrl_data_index = 32'd100; dma_write_ctrl_data_length = 32'd4;
        dma_read_ctrl_valid  = 1'b1; dma_read_ctrl_data_index  = 32'd100; dma_read_ctrl_data_length  = 32'd4;
        #2;
        chk("arb1_rd_ready", dma_read_ctrl_ready, 1'b1);
        chk("arb1_wr_ready", dma_write_ctrl_ready, 1'b0);
        rd_task(32'd100, 32'd4, 1'b0, 1'b1);
        chk("arb1_rd_old", last_beat, 64'hA3);
        wr_task(32'd100, 32'd4, 64'hB0);

        // Both requests together again: now write wins
        dma_write_ctrl_valid = 1'b1; dma_write_ctrl_data_index = 32'd100; dma_write_ctrl_data_length = 32'd2;
        dma_read_ctrl_valid  = 1'b1; dma_read_ctrl_data_index  = 32'd100; dma_read_ctrl_data_length  = 32'd2;
        #2;
        chk("arb2_rd_ready", dma_read_ctrl_ready, 1'b0);
        chk("arb2_wr_ready", dma_write_ctrl_ready, 1'b1);
        wr_task(32'd100, 32'd2, 64'hC0);
        rd_task(32'd100, 32'd2, 1'b0, 1'b1);
        chk("arb2_rd_new", last_beat, 64'hC1);

        // Length 0 with a colliding host write that must be dropped
        nbeats = 0;
        host_en = 1'b1; host_we = 1'b1; host_addr = AW'(5); host_wdata = 64'hBAD;
        rd_task(32'd7, 32'd0, 1'b0, 1'b0);
        #2;
        chk("len0_busy", busy, 1'b1);
        host_en = 1'b0; host_we = 1'b0;
        @(posedge clk); #1;
        chk("len0_idle", busy, 1'b0);
        chk("len0_nobeats", nbeats, 0);
        host_rd("host_collide", AW'(5), 64'd5);

        // Crossing the top of memory
        rd_task(32'(DEPTH - 2), 32'd4, 1'b0, 1'b1);
        chk("oob_last", last_beat, BOUNDS ? 64'hDEADBEEF_DEADBEEF : 64'd1);
        chk("oob_flag", err_oob, 64'(BOUNDS));

        // Reset during the third beat of a length-8 read
        nbeats = 0;
        rd_task(32'd0, 32'd8, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        exp_q.delete();
        #2;
        chk_reset_outputs("mid");
        chk("mid_beats_before", nbeats, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        host_rd("post_rst_rd3", AW'(3), 64'd3);
        for (int i = 0; i < 8; i++) host_rd("post_rst_rd", AW'(i), mdl[i]);
        rd_task(32'd4, 32'd2, 1'b0, 1'b1);
        chk("post_rst_read", last_beat, 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
